rf_write_arbiter: RTL and testbench

Shares the register file's single write port between three writers: the core writeback path, the multi-cycle multiply/divide unit (MDU) and the UART debug loader. Also keeps a per-register busy scoreboard for MDU results still in flight and drives the core's hazard stall. Sits between the writers and the register file write inputs (Write, Write_register, Write_data).

---
 rtl/rf_arb_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 46 ++++
 rtl/rf_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared widths and grant encoding for the register file write arbiter.
package rf_arb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_MDU  = 2'd2,
        GNT_DBG  = 2'd3
    } gnt_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for registers with an MDU result still in flight.
// Register 0 is never busy; a same-cycle set and clear of one register leaves it set.
module rf_scoreboard
    import rf_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] look_rs,
    input  logic [REG_AW-1:0] look_rt,
    input  logic [REG_AW-1:0] look_rd,
    output logic              busy_rs,
    output logic              busy_rt,
    output logic              busy_rd
);

    logic [31:1] busy;
    logic [31:0] busy_full;

    // Per-register set/clear; the set is applied last so it wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (set_en && set_rd == REG_AW'(i)) begin
                    busy[i] <= 1'b1;
                end else if (clr_en && clr_rd == REG_AW'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Lookups read registered state only, with r0 padded in as not busy.
    always_comb begin
        busy_full = {busy, 1'b0};
        busy_rs   = busy_full[look_rs];
        busy_rt   = busy_full[look_rt];
        busy_rd   = busy_full[look_rd];
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Single write port arbiter: core first, MDU/debug round-robin behind it,
// with a starvation hold on the core and the MDU hazard scoreboard.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_we,
    input  logic [REG_AW-1:0] c_rd,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              m_valid,
    input  logic [REG_AW-1:0] m_rd,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_ready,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rd,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic [REG_AW-1:0] hz_rs,
    input  logic [REG_AW-1:0] hz_rt,
    output logic              hazard,
    output logic              core_hold,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              err_core_hold
);

    localparam logic [8:0] LIMIT = 9'(STARVE_LIMIT);

    gnt_t       gnt;
    logic       core_req;
    logic       rr_dbg;
    logic [7:0] starve_cnt;
    logic [8:0] starve_inc;
    logic       busy_rs;
    logic       busy_rt;
    logic       busy_rd;

    assign core_req = c_we && (c_rd != '0);

    // Grant selection: core wins outright, otherwise round-robin between MDU and debug.
    always_comb begin
        gnt = GNT_NONE;
        if (core_req) begin
            gnt = GNT_CORE;
        end else if (m_valid && d_valid) begin
            gnt = rr_dbg ? GNT_DBG : GNT_MDU;
        end else if (m_valid) begin
            gnt = GNT_MDU;
        end else if (d_valid) begin
            gnt = GNT_DBG;
        end
    end

    // Port mux; a granted rd=0 request is acked without driving a write.
    always_comb begin
        m_ready = 1'b0;
        d_ready = 1'b0;
        rf_we   = 1'b0;
        rf_wa   = '0;
        rf_wd   = '0;
        case (gnt)
            GNT_CORE: begin
                rf_we = 1'b1;
                rf_wa = c_rd;
                rf_wd = c_wdata;
            end
            GNT_MDU: begin
                m_ready = 1'b1;
                if (m_rd != '0) begin
                    rf_we = 1'b1;
                    rf_wa = m_rd;
                    rf_wd = m_wdata;
                end
            end
            GNT_DBG: begin
                d_ready = 1'b1;
                if (d_rd != '0) begin
                    rf_we = 1'b1;
                    rf_wa = d_rd;
                    rf_wd = d_wdata;
                end
            end
            default: ;
        endcase
    end

    // Round-robin pointer flips to the other secondary after each secondary grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_dbg <= 1'b0;
        end else if (gnt == GNT_MDU) begin
            rr_dbg <= 1'b1;
        end else if (gnt == GNT_DBG) begin
            rr_dbg <= 1'b0;
        end
    end

    assign starve_inc = {1'b0, starve_cnt} + 9'd1;

    // Starvation counter; reaching the limit raises core_hold for one cycle and restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            core_hold  <= 1'b0;
        end else if (m_ready || d_ready || !(m_valid || d_valid)) begin
            starve_cnt <= '0;
            core_hold  <= 1'b0;
        end else if (starve_inc >= LIMIT) begin
            starve_cnt <= '0;
            core_hold  <= 1'b1;
        end else begin
            starve_cnt <= starve_inc[7:0];
            core_hold  <= 1'b0;
        end
    end

    // Sticky error when the core ignores its hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_core_hold <= 1'b0;
        end else if (core_hold && core_req) begin
            err_core_hold <= 1'b1;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (iss_valid && (iss_rd != '0)),
        .set_rd  (iss_rd),
        .clr_en  (m_valid && m_ready),
        .clr_rd  (m_rd),
        .look_rs (hz_rs),
        .look_rt (hz_rt),
        .look_rd (c_rd),
        .busy_rs (busy_rs),
        .busy_rt (busy_rt),
        .busy_rd (busy_rd)
    );

    assign hazard = busy_rs || busy_rt || (c_we && busy_rd);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_we;
    logic [4:0]  c_rd;
    logic [31:0] c_wdata;
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        d_valid;
    logic [4:0]  d_rd;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  hz_rs;
    logic [4:0]  hz_rt;
    logic        hazard;
    logic        core_hold;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        err_core_hold;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .c_we          (c_we),
        .c_rd          (c_rd),
        .c_wdata       (c_wdata),
        .m_valid       (m_valid),
        .m_rd          (m_rd),
        .m_wdata       (m_wdata),
        .m_ready       (m_ready),
        .d_valid       (d_valid),
        .d_rd          (d_rd),
        .d_wdata       (d_wdata),
        .d_ready       (d_ready),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .hz_rs         (hz_rs),
        .hz_rt         (hz_rt),
        .hazard        (hazard),
        .core_hold     (core_hold),
        .rf_we         (rf_we),
        .rf_wa         (rf_wa),
        .rf_wd         (rf_wd),
        .err_core_hold (err_core_hold)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        c_we = 0; c_rd = 0; c_wdata = 0;
        m_valid = 0; m_rd = 0; m_wdata = 0;
        d_valid = 0; d_rd = 0; d_wdata = 0;
        iss_valid = 0; iss_rd = 0; hz_rs = 0; hz_rt = 0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Core writes r3 every cycle with debug pending; hold on cycle 9.
    task automatic starve_run(input bit honour);
        do_reset();
        c_we = 1; c_rd = 3; c_wdata = 32'h33;
        d_valid = 1; d_rd = 10; d_wdata = 32'hD0D0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            #1;
            chk($sformatf("starve_hold_c%0d", cyc), 32'(core_hold), 0);
            chk($sformatf("starve_dready_c%0d", cyc), 32'(d_ready), 0);
            tick();
        end
        if (honour) c_we = 0;
        #1;
        chk("hold_c9", 32'(core_hold), 1);
        chk("dready_c9", 32'(d_ready), honour ? 1 : 0);
        chk("wa_c9", 32'(rf_wa), honour ? 10 : 3);
        tick();
        c_we = 1; d_valid = honour ? 1'b0 : 1'b1;
        #1;
        chk("hold_c10", 32'(core_hold), 0);
        chk("err_c10", 32'(err_core_hold), honour ? 0 : 1);
    endtask

    initial begin
        idle();
        reset = 1;
        #12;
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_hazard", 32'(hazard), 0);
        chk("rst_hold", 32'(core_hold), 0);
        chk("rst_err", 32'(err_core_hold), 0);
        chk("rst_mready", 32'(m_ready), 0);
        chk("rst_dready", 32'(d_ready), 0);
        tick();
        reset = 0;
        tick();

        // Core beats the MDU, MDU goes next cycle.
        c_we = 1; c_rd = 5; c_wdata = 32'h1234;
        m_valid = 1; m_rd = 6; m_wdata = 32'hAAAA;
        #1;
        chk("core_we", 32'(rf_we), 1);
        chk("core_wa", 32'(rf_wa), 5);
        chk("core_wd", rf_wd, 32'h1234);
        chk("core_mready", 32'(m_ready), 0);
        tick();
        c_we = 0;
        #1;
        chk("mdu_wa", 32'(rf_wa), 6);
        chk("mdu_wd", rf_wd, 32'hAAAA);
        chk("mdu_mready", 32'(m_ready), 1);
        tick();

        // Core write to r0 does not take the port.
        idle();
        c_we = 1; c_rd = 0; c_wdata = 32'hFFFF;
        d_valid = 1; d_rd = 12; d_wdata = 32'h5555;
        #1;
        chk("r0core_dready", 32'(d_ready), 1);
        chk("r0core_wa", 32'(rf_wa), 12);

        // Round-robin from reset: M, D, M, D.
        do_reset();
        m_valid = 1; m_rd = 8; m_wdata = 32'h88;
        d_valid = 1; d_rd = 9; d_wdata = 32'h99;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_m%0d", i), 32'(m_ready), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_d%0d", i), 32'(d_ready), (i % 2 == 1) ? 1 : 0);
            chk($sformatf("rr_wa%0d", i), 32'(rf_wa), (i % 2 == 0) ? 8 : 9);
            tick();
        end

        // Scoreboard: issue r7, no same-cycle hazard, busy until MDU write commits.
        idle();
        iss_valid = 1; iss_rd = 7; hz_rs = 7;
        #1;
        chk("sb_same_cycle", 32'(hazard), 0);
        tick();
        iss_valid = 0;
        #1;
        chk("sb_rs_busy", 32'(hazard), 1);
        hz_rs = 0; hz_rt = 7;
        #1;
        chk("sb_rt_busy", 32'(hazard), 1);
        hz_rt = 0; c_rd = 7;
        #1;
        chk("sb_crd_no_we", 32'(hazard), 0);
        c_we = 1;
        #1;
        chk("sb_crd_we", 32'(hazard), 1);
        tick();
        c_we = 0; c_rd = 0; hz_rs = 7;
        m_valid = 1; m_rd = 7; m_wdata = 32'h77;
        #1;
        chk("sb_clr_cycle_mready", 32'(m_ready), 1);
        chk("sb_clr_cycle_hazard", 32'(hazard), 1);
        tick();
        m_valid = 0;
        #1;
        chk("sb_cleared", 32'(hazard), 0);
        iss_valid = 1; iss_rd = 7;
        tick();
        m_valid = 1; m_rd = 7;
        #1;
        chk("sb_setclr_mready", 32'(m_ready), 1);
        tick();
        iss_valid = 0; m_valid = 0;
        #1;
        chk("sb_set_wins", 32'(hazard), 1);
        m_valid = 1;
        tick();
        m_valid = 0;
        #1;
        chk("sb_final_clear", 32'(hazard), 0);

        starve_run(1'b1);
        starve_run(1'b0);
        tick();
        tick();
        #1;
        chk("err_sticky", 32'(err_core_hold), 1);
        do_reset();
        #1;
        chk("err_reset", 32'(err_core_hold), 0);

        // Reset mid-operation: busy[4] set, rr at D, counter at 5.
        m_valid = 1; m_rd = 0; iss_valid = 1; iss_rd = 4;
        #1;
        chk("r0mdu_ack", 32'(m_ready), 1);
        chk("r0mdu_nowe", 32'(rf_we), 0);
        tick();
        idle();
        hz_rs = 4;
        c_we = 1; c_rd = 3; d_valid = 1; d_rd = 11;
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("mid_hazard", 32'(hazard), 1);
        reset = 1;
        c_we = 0; d_valid = 0;
        #1;
        chk("mid_rst_hazard", 32'(hazard), 0);
        chk("mid_rst_hold", 32'(core_hold), 0);
        chk("mid_rst_we", 32'(rf_we), 0);
        tick();
        reset = 0;
        m_valid = 1; m_rd = 13; d_valid = 1; d_rd = 14;
        #1;
        chk("mid_rr_m", 32'(m_ready), 1);
        chk("mid_rr_d", 32'(d_ready), 0);
        tick();
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
